// File: rtl/multi_stage_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : multi_stage_synchronizer
// Description : WIDTH-channel N-flop CDC synchronizer with per-channel
//               stability filter and registered rise/fall/changed pulses.
//               Optional SYNC_GLITCH_CNT_EN adds a saturating glitch counter.
// Revision    : 1.0 - initial release
// ============================================================================
module multi_stage_synchronizer #(
    parameter int               WIDTH         = 1,
    parameter int               SYNC_STAGES   = 2,
    parameter int               FILTER_CYCLES = 0,
    parameter logic [WIDTH-1:0] RESET_VALUE   = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    output logic [WIDTH-1:0] out,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             changed
`ifdef SYNC_GLITCH_CNT_EN
    ,
    output logic [15:0]      glitch_cnt
`endif
);

    localparam int                 c_CNT_W = (FILTER_CYCLES > 0) ? $clog2(FILTER_CYCLES + 1) : 1;
    localparam logic [c_CNT_W-1:0] c_FILT  = c_CNT_W'(FILTER_CYCLES);

    if (SYNC_STAGES < 2) begin : g_bad_stages
        $error("multi_stage_synchronizer: SYNC_STAGES must be >= 2");
    end

    (* ASYNC_REG = "TRUE" *) logic [WIDTH-1:0] r_sync [SYNC_STAGES];
    logic [c_CNT_W-1:0] r_cnt     [WIDTH];
    logic [c_CNT_W-1:0] w_cnt_nxt [WIDTH];
    logic [WIDTH-1:0]   w_s_last;
    logic [WIDTH-1:0]   w_differ;
    logic [WIDTH-1:0]   w_out_nxt;

    assign w_s_last = r_sync[SYNC_STAGES-1];

    // Pure shift chain: nothing but the next stage may sample these flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                r_sync[k] <= RESET_VALUE;
            end
        end else begin
            r_sync[0] <= in;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                r_sync[k] <= r_sync[k-1];
            end
        end
    end

    // A channel's output follows only after FILTER_CYCLES+1 differing samples.
    always_comb begin
        w_out_nxt = out;
        w_differ  = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_cnt_nxt[i] = '0;
            w_differ[i]  = w_s_last[i] ^ out[i];
            if (w_differ[i]) begin
                if (r_cnt[i] == c_FILT) begin
                    w_out_nxt[i] = w_s_last[i];
                end else begin
                    w_cnt_nxt[i] = r_cnt[i] + c_CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
            out     <= RESET_VALUE;
            rise    <= '0;
            fall    <= '0;
            changed <= 1'b0;
        end else begin
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= w_cnt_nxt[i];
            end
            out     <= w_out_nxt;
            rise    <= w_out_nxt & ~out;
            fall    <= ~w_out_nxt & out;
            changed <= |(w_out_nxt ^ out);
        end
    end

`ifdef SYNC_GLITCH_CNT_EN
    logic w_reject;

    // A rejection is a partial count abandoned because the sample fell back.
    always_comb begin
        w_reject = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (!w_differ[i] && (r_cnt[i] != '0)) begin
                w_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            glitch_cnt <= 16'h0000;
        end else if (w_reject && (glitch_cnt != 16'hFFFF)) begin
            glitch_cnt <= glitch_cnt + 16'd1;
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_multi_stage_synchronizer.sv
`default_nettype none
// ============================================================================
// Module      : tb_multi_stage_synchronizer
// Description : Directed self-checking bench for multi_stage_synchronizer,
//               covering a filtered 4-channel and an unfiltered 1-channel build.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_multi_stage_synchronizer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] in_a = 4'b0000;
    logic [3:0] out_a, rise_a, fall_a;
    logic       changed_a;
    logic [0:0] in_b = 1'b1;
    logic [0:0] out_b, rise_b, fall_b;
    logic       changed_b;
`ifdef SYNC_GLITCH_CNT_EN
    logic [15:0] glitch_a, glitch_b;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    multi_stage_synchronizer #(
        .WIDTH(4), .SYNC_STAGES(3), .FILTER_CYCLES(2), .RESET_VALUE(4'b0000)
    ) u_dut_a (
        .clk(clk), .rst(rst), .in(in_a), .out(out_a),
        .rise(rise_a), .fall(fall_a), .changed(changed_a)
`ifdef SYNC_GLITCH_CNT_EN
        , .glitch_cnt(glitch_a)
`endif
    );

    multi_stage_synchronizer #(
        .WIDTH(1), .SYNC_STAGES(2), .FILTER_CYCLES(0), .RESET_VALUE(1'b1)
    ) u_dut_b (
        .clk(clk), .rst(rst), .in(in_b), .out(out_b),
        .rise(rise_b), .fall(fall_b), .changed(changed_b)
`ifdef SYNC_GLITCH_CNT_EN
        , .glitch_cnt(glitch_b)
`endif
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        // Power-on reset
        tick();
        tick();
        check("por_out_a", 32'(out_a), 32'h0);
        check("por_out_b", 32'(out_b), 32'h1);
        check("por_pulses_a", 32'({rise_a, fall_a, changed_a}), 32'h0);
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            tick();
            check("b_held_out", 32'(out_b), 32'h1);
            check("b_held_pulse", 32'({rise_b, fall_b, changed_b}), 32'h0);
        end

        // Mid-operation async reset with no clock edge
        in_a = 4'b1111;
        for (int k = 1; k <= 10; k++) tick();
        check("a_all_high", 32'(out_a), 32'hF);
        rst = 1'b1;
        #1;
        check("async_rst_out", 32'(out_a), 32'h0);
        check("async_rst_pulses", 32'({rise_a, fall_a, changed_a}), 32'h0);
        in_a = 4'b0000;
        #2;
        rst = 1'b0;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if ({rise_a, fall_a, changed_a, out_a} !== 13'h0) bad++;
        end
        check("post_rst_quiet", 32'(bad), 32'd0);

        // Single-channel latency: accepted after edge 6
        in_a = 4'b0001;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("lat_out_e%0d", k), 32'(out_a), (k >= 6) ? 32'h1 : 32'h0);
            check($sformatf("lat_rise_e%0d", k), 32'({rise_a, changed_a}), (k == 6) ? 32'h3 : 32'h0);
            check($sformatf("lat_fall_e%0d", k), 32'(fall_a), 32'h0);
        end
        in_a = 4'b0000;
        for (int k = 1; k <= 10; k++) tick();
        check("lat_back_low", 32'(out_a), 32'h0);

        // Two-cycle glitch on channel 1 is rejected
        pulse_reset();
`ifdef SYNC_GLITCH_CNT_EN
        check("glitch_after_rst", 32'(glitch_a), 32'h0);
`endif
        in_a = 4'b0010;
        bad = 0;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 2) in_a = 4'b0000;
            if ({rise_a, fall_a, changed_a, out_a} !== 13'h0) bad++;
        end
        check("glitch2_rejected", 32'(bad), 32'd0);
`ifdef SYNC_GLITCH_CNT_EN
        check("glitch2_count", 32'(glitch_a), 32'h1);
`endif

        // Three-cycle pulse on channel 1 is accepted, then released
        in_a = 4'b0010;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k == 3) in_a = 4'b0000;
            check($sformatf("p3_out_e%0d", k), 32'(out_a), (k >= 6 && k <= 8) ? 32'h2 : 32'h0);
            check($sformatf("p3_rise_e%0d", k), 32'(rise_a), (k == 6) ? 32'h2 : 32'h0);
            check($sformatf("p3_fall_e%0d", k), 32'(fall_a), (k == 9) ? 32'h2 : 32'h0);
        end
`ifdef SYNC_GLITCH_CNT_EN
        check("p3_count", 32'(glitch_a), 32'h1);
`endif

        // Simultaneous opposite transitions across channels
        in_a = 4'b1010;
        for (int k = 1; k <= 10; k++) tick();
        check("multi_settled", 32'(out_a), 32'hA);
        in_a = 4'b0101;
        for (int k = 1; k <= 5; k++) tick();
        check("multi_e5_out", 32'(out_a), 32'hA);
        check("multi_e5_changed", 32'(changed_a), 32'h0);
        tick();
        check("multi_out", 32'(out_a), 32'h5);
        check("multi_rise", 32'(rise_a), 32'h5);
        check("multi_fall", 32'(fall_a), 32'hA);
        check("multi_changed", 32'(changed_a), 32'h1);
        tick();
        check("multi_after", 32'({rise_a, fall_a, changed_a}), 32'h0);

        // Unfiltered two-stage build: fall then rise after edge 3
        in_b = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("b_fall_out_e%0d", k), 32'(out_b), (k >= 3) ? 32'h0 : 32'h1);
            check($sformatf("b_fall_e%0d", k), 32'({fall_b, changed_b}), (k == 3) ? 32'h3 : 32'h0);
            check($sformatf("b_fall_rise_e%0d", k), 32'(rise_b), 32'h0);
        end
        in_b = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            tick();
            check($sformatf("b_rise_out_e%0d", k), 32'(out_b), (k >= 3) ? 32'h1 : 32'h0);
            check($sformatf("b_rise_e%0d", k), 32'({rise_b, changed_b}), (k == 3) ? 32'h3 : 32'h0);
        end
`ifdef SYNC_GLITCH_CNT_EN
        check("b_glitch_zero", 32'(glitch_b), 32'h0);

        // Saturation: channels 2 and 3 glitch on alternate cycles
        pulse_reset();
        in_a = 4'b0000;
        for (int k = 1; k <= 5; k++) tick();
        bad = 0;
        for (int k = 0; k < 70000; k++) begin
            in_a = {~k[0], k[0], 2'b00};
            tick();
            if (out_a !== 4'b0000 || changed_a !== 1'b0) bad++;
        end
        in_a = 4'b0000;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (out_a !== 4'b0000 || changed_a !== 1'b0) bad++;
        end
        check("sat_out_stable", 32'(bad), 32'd0);
        check("sat_glitch_cnt", 32'(glitch_a), 32'hFFFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multi_stage_synchronizer.md
Name: multi_stage_synchronizer

Overview:
- Parametrised successor to the fixed two-flop synchronizer: WIDTH independent channels, configurable stage count SYNC_STAGES, reset value, and a per-channel stability filter.
- Emits single-cycle rise/fall pulses on each filtered output change.
- Sits at every asynchronous-input boundary: FIFO pointer/flag crossings, external level signals, slow control lines into the clk domain.

Parameters:
- WIDTH, 1, number of independent single-bit channels.
- SYNC_STAGES, 2, flops per synchronizer chain; must be >= 2, otherwise elaboration error.
- FILTER_CYCLES, 0, extra consecutive cycles a synced value must differ from out before out follows; 0 = no filtering.
- RESET_VALUE, {WIDTH{1'b0}}, value loaded into every chain flop and into out on reset.

Ports:
- clk  input  1  destination-domain clock; all flops rising-edge.
- rst  input  1  asynchronous, active-high reset.
- in  input  WIDTH  asynchronous inputs, no timing relation to clk.
- out  output  WIDTH  synchronized, filtered level.
- rise  output  WIDTH  1-cycle pulse, per channel, on out 0->1.
- fall  output  WIDTH  1-cycle pulse, per channel, on out 1->0.
- changed  output  1  1-cycle pulse; OR of rise|fall.

Behaviour:
- Reset (rst=1, async, no clock needed):
  - All chain stages and out = RESET_VALUE.
  - Filter counters = 0.
  - rise, fall, changed = 0.
  - Reset asserted mid-operation discards in-flight values and counts; no pulse is generated at reset release.
- Chain, per channel i: s[0] <= in[i]; s[k] <= s[k-1]; s_last = s[SYNC_STAGES-1]. Chain flops hold no other logic and have no fan-out except the next stage.
- Filter, per channel, counter cnt of width max(1, clog2(FILTER_CYCLES+1)), evaluated each edge:
  - s_last == out: cnt <= 0, out holds.
  - s_last != out and cnt == FILTER_CYCLES: out <= s_last, cnt <= 0.
  - s_last != out and cnt < FILTER_CYCLES: cnt <= cnt+1, out holds.
- Acceptance: s_last must differ from out for FILTER_CYCLES+1 consecutive evaluations. A difference lasting <= FILTER_CYCLES cycles is rejected, with no change on out.
- Latency: an in change stable before edge 1 appears on out after edge SYNC_STAGES+1+FILTER_CYCLES. For the defaults this is edge 3.
- Pulses:
  - rise[i]/fall[i] are registered and asserted in the same cycle out[i] changes, for exactly one cycle.
  - Back-to-back accepted toggles give separate pulses.
  - Channels are fully independent; simultaneous changes on several channels pulse in the same cycle.
  - changed = |(rise|fall), registered with them.
- Out never changes twice in consecutive cycles when FILTER_CYCLES >= 1.

Optional Feature:
- Macro: SYNC_GLITCH_CNT_EN.
- Defined: adds output glitch_cnt [15:0], reset to 0 asynchronously.
  - A rejection is any channel with s_last == out while cnt != 0.
  - glitch_cnt increments by 1 in any cycle where at least one channel rejects, then saturates at 16'hFFFF.
  - With FILTER_CYCLES=0 it stays 0.
- Undefined: no port and no logic; all other behaviour identical.

Test Plan:
- WIDTH=4, SYNC_STAGES=3, FILTER_CYCLES=2: run with in=4'b1111 and out=4'b1111, then assert rst between edges with no clock edge. Required: out=0, rise=fall=0, changed=0 immediately. After release with in=4'b0000: no pulses.
- Same config, in[0] 0->1 before edge 1. Required:
  - out[0]=1 after edge 6.
  - rise[0]=1 and changed=1 for exactly that one cycle.
  - out[3:1] unchanged.
- Same config, in[1] high for exactly 2 cycles: out[1] stays 0, no pulse, glitch_cnt=1 (when SYNC_GLITCH_CNT_EN). Then high for 3 cycles: out[1]=1 for 3 cycles, rise then fall 3 cycles apart.
- Same config: in=4'b1010 settled, then in=4'b0101. Required: in one cycle, rise=4'b0101, fall=4'b1010, changed=1, out=4'b0101.
- WIDTH=1, SYNC_STAGES=2, FILTER_CYCLES=0, RESET_VALUE=1: after reset out=1 with in held 1, no pulse. Then in->0: out=0 after edge 3 and fall=1 for one cycle.
- SYNC_GLITCH_CNT_EN, FILTER_CYCLES=2: inject 70000 one-cycle glitches. Required: glitch_cnt saturates at 16'hFFFF and out never changes.
